// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_FLUSH, S_HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc/inst holding register that catches a fetch returning while the output slot is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (unload || flush) valid_d = 1'b0;
    if (load) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out   = pc_q;
  assign inst_out = inst_q;
  assign valid    = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, skids one
// instruction under stall and redirects on taken branches.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stalling,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] inst_data_out,
  output logic        ACK_out
);
  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  inst_q, inst_d;
  logic         ack_q, ack_d;

  logic         skid_load, skid_unload, skid_flush, skid_valid;
  logic [31:0]  skid_pc, skid_inst;
  logic [31:0]  target;
  logic         slot_free;

  assign target    = branch_target & ~32'h3;
  assign slot_free = ~ack_q | ~stalling;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .unload  (skid_unload),
    .flush   (skid_flush),
    .pc_in   (fetch_pc_q),
    .inst_in (imem_rdata),
    .pc_out  (skid_pc),
    .inst_out(skid_inst),
    .valid   (skid_valid)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    pc_out_d      = pc_out_q;
    inst_d        = inst_q;
    ack_d         = ack_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            fetch_pc_d = target;
            ack_d      = 1'b0;
          end else if (slot_free) begin
            pc_out_d   = fetch_pc_q;
            inst_d     = imem_rdata;
            ack_d      = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end else begin
            skid_load  = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = S_HOLD;
          end
        end else if (branch_taken) begin
          // Request must stay on the old address until acked, so park the target.
          redirect_pc_d = target;
          ack_d         = 1'b0;
          state_d       = S_FLUSH;
        end else if (~stalling) begin
          ack_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          skid_flush = 1'b1;
          ack_d      = 1'b0;
          fetch_pc_d = target;
          state_d    = S_REQ;
        end else if (~stalling && skid_valid) begin
          skid_unload = 1'b1;
          pc_out_d    = skid_pc;
          inst_d      = skid_inst;
          ack_d       = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_FLUSH: begin
        ack_d = 1'b0;
        if (branch_taken) redirect_pc_d = target;
        if (imem_ack) begin
          fetch_pc_d = branch_taken ? target : redirect_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      pc_out_q      <= '0;
      inst_q        <= NOP_INST;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      pc_out_q      <= pc_out_d;
      inst_q        <= inst_d;
      ack_q         <= ack_d;
    end
  end

  assign imem_req      = ~reset && (state_q != S_HOLD);
  assign imem_addr     = fetch_pc_q;
  assign PC_out        = pc_out_q;
  assign inst_data_out = inst_q;
  assign ACK_out       = ack_q;
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, drives the instruction-memory request/acknowledge handshake, absorbs stalls with a one-entry skid buffer and redirects on taken branches. Its outputs feed the IF/ID pipeline register directly. `ACK_out` marks a valid fetched instruction, and the IF/ID register captures it on any edge where `stalling` is low.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stalling` in 1: hazard-unit stall. The IF/ID register holds while it is high.
- `branch_taken` in 1: redirect request from EX.
- `branch_target` in 32: redirect address. Bits [1:0] are treated as 0.
- `imem_req` out 1: memory request valid.
- `imem_addr` out 32: request address.
- `imem_ack` in 1: memory acknowledge. One-cycle pulse per request; may occur in the same cycle `imem_req` first rises.
- `imem_rdata` in 32: instruction word, valid only in the `imem_ack` cycle.
- `PC_out` out 32: address of the presented instruction.
- `inst_data_out` out 32: presented instruction.
- `ACK_out` out 1: presented instruction is valid.

## Operation
- Registers:
  - `fetch_pc`: address of the outstanding or next request.
  - Output registers: `PC_out`, `inst_data_out`, `ACK_out`.
  - Skid entry: pc, inst, valid.
  - `redirect_pc`.
  - State.
- "Consumed" means `~stalling` at the edge. The output slot is free if `ACK_out`=0 or the presented instruction is consumed at this edge.
- **S_REQ**
  - Drives `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - On an ack edge with `branch_taken`: drop `imem_rdata`, set `fetch_pc`<=target, set `ACK_out`<=0, stay in S_REQ.
  - On an ack edge, no branch, slot free: load the output registers (`PC_out`<=`fetch_pc`, `inst_data_out`<=`imem_rdata`, `ACK_out`<=1), set `fetch_pc`+=4, stay in S_REQ.
  - On an ack edge, no branch, slot not free: load the skid entry, set `fetch_pc`+=4, go to S_HOLD.
  - No ack, with `branch_taken`: set `redirect_pc`<=target, `ACK_out`<=0, go to S_FLUSH. The address must stay stable until ack.
  - No ack, no branch: if consumed, `ACK_out`<=0.
- **S_HOLD**
  - `imem_req`=0.
  - If `branch_taken`: clear skid valid, set `ACK_out`<=0, `fetch_pc`<=target, go to S_REQ.
  - Else if `~stalling`: move the skid entry into the output registers with `ACK_out`<=1, go to S_REQ.
- **S_FLUSH**
  - Drives `imem_req`=1 with the old `fetch_pc`.
  - A further `branch_taken` overwrites `redirect_pc`; the newest target wins, including on the ack edge.
  - On ack: discard the data, set `fetch_pc`<=`redirect_pc`, go to S_REQ.
  - `ACK_out` stays 0.
- `branch_taken` has priority over `stalling` and always clears `ACK_out` at that edge.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- **Reset**
  - State=S_REQ, `fetch_pc`=`RESET_PC`, `PC_out`=0, `inst_data_out`=32'h0000_0013 (NOP), `ACK_out`=0, skid valid=0, `redirect_pc`=0.
  - `imem_req` is gated low while `reset` is high.
  - Reset mid-request abandons it; a late ack after reset is ignored only if it coincides with `reset` high.

## Timing
- `imem_req`/`imem_addr` are combinational from state and `fetch_pc`. Output registers change only on clock edges.
- With a same-cycle-ack memory, a fetch issued in cycle N presents `ACK_out`=1 in cycle N+1. Throughput is 1 instruction/cycle with no stalls.
- With k-cycle ack latency, throughput is 1 per (k+1) cycles.
- First `imem_req` is in the first cycle after `reset` falls.
- Redirect costs: 1 cycle in S_REQ with ack; remaining memory latency plus 1 otherwise.
- Stall release out of S_HOLD re-presents the skid instruction at the next edge. The new request issues in the following cycle.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic [1:0] {S_REQ, S_FLUSH, S_HOLD} fetch_state_t`.
  - `NOP_INST` = 32'h0000_0013.
  - `PC_STEP` = 4.
- Sub-module `fetch_skid_buf`: one-entry pc/inst holding register with load, unload and flush. Everything else is inline.

## Test plan
- Reset with `RESET_PC`=32'h100 and same-cycle ack, no stalls → addresses 0x100, 0x104, 0x108 on consecutive cycles. `ACK_out`=1 from the cycle after the first request. `inst_data_out` matches the memory model.
- Hold `stalling` high for 3 cycles mid-stream → exactly one instruction skidded, FSM in S_HOLD, `imem_req`=0. On release, 0x108 is presented, followed by 0x10C with no loss or duplicate.
- 3-cycle ack latency, `branch_taken` with target 0x200 asserted one cycle after a request to 0x110 → `imem_addr` stays 0x110 until ack. Data is dropped, the next request is 0x200, and `ACK_out` is never 1 for 0x110.
- `branch_taken` and `stalling` both high on an ack edge → `ACK_out`=0, `fetch_pc`=target, no skid load.
- `RESET_PC`=32'hFFFF_FFF8 → fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` while in S_FLUSH → outputs return to reset values, the next request is to `RESET_PC`, and `redirect_pc` is ignored.
